// File: rtl/jtag_pkg.sv
// Shared definitions for the USER4 result return path.
// Frame width depends on JTAG_RESULT_PARITY_EN (adds an even-parity MSB).
package jtag_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

`ifdef JTAG_RESULT_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int unsigned frame_width(input int unsigned dw);
    return dw + 32'd1 + 32'(PARITY_EN);
  endfunction

  localparam int unsigned FRAME_W   = frame_width(DEFAULT_DATA_W);
  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned DATA_LSB  = 1;

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [1:0] {
    TAP_IDLE,
    TAP_CAPTURE,
    TAP_SHIFT,
    TAP_UPDATE
  } tap_op_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO; power-of-two depth, pointers wrap naturally.
module result_fifo
  import jtag_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtag_result_sender.sv
// USER4 DR return path: buffers solver results and shifts them out on tdo.
// Optional even-parity frame bit enabled by JTAG_RESULT_PARITY_EN.
module jtag_result_sender
  import jtag_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  tck,
  input  logic                  test_logic_reset_n,
  input  logic                  ir_is_user,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  overflow
);

  localparam int unsigned FW = frame_width(DATA_WIDTH);
  localparam int unsigned CW = $clog2(FW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FW);

  tap_op_e               op;
  logic [FW-1:0]         sr;
  logic [FW-1:0]         cap_frame;
  logic [CW-1:0]         cnt;
  logic                  armed;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (tck),
    .rst_n (test_logic_reset_n),
    .push  (res_valid),
    .pop   (pop),
    .din   (res_data),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // TAP states are mutually exclusive; the priority here is only for decode.
  always_comb begin
    op = TAP_IDLE;
    if (ir_is_user) begin
      if (capture_dr)     op = TAP_CAPTURE;
      else if (shift_dr)  op = TAP_SHIFT;
      else if (update_dr) op = TAP_UPDATE;
    end
  end

  always_comb begin
    cap_frame = '0;
    if (!empty) begin
      cap_frame[VALID_BIT]             = 1'b1;
      cap_frame[DATA_LSB +: DATA_WIDTH] = head;
`ifdef JTAG_RESULT_PARITY_EN
      cap_frame[FW-1] = ^cap_frame[FW-2:0];
`endif
    end
  end

  assign pop       = (op == TAP_UPDATE) && armed && (cnt == CNT_FULL);
  assign res_ready = !full;
  assign tdo       = sr[0];

  always_ff @(posedge tck or negedge test_logic_reset_n) begin
    if (!test_logic_reset_n) begin
      sr       <= '0;
      cnt      <= '0;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (res_valid && full) overflow <= 1'b1;
      case (op)
        TAP_CAPTURE: begin
          sr    <= cap_frame;
          cnt   <= '0;
          armed <= !empty;
        end
        TAP_SHIFT: begin
          sr <= {tdi, sr[FW-1:1]};
          if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
        end
        TAP_UPDATE: armed <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
